// File: rtl/spm_pkg.sv
// Shared definitions for the serial-parallel multiplier front-end: sequencer state
// encoding, default operand width and the shift-counter width helper.
package spm_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_RES  = 2'b10
  } seq_state_e;

  localparam int SPM_N = 8;

  // Counter must hold 0..2n inclusive
  function automatic int spm_cnt_w(input int n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/spm_res_sipo.sv
// Serial-in parallel-out result register: bits enter at the MSB and move towards the LSB,
// so an LSB-first serial product ends up correctly aligned after W shifts.
module spm_res_sipo #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         bit_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q;
  logic [W-1:0] q_d;

  // Clear has priority over a shift so a new operation never inherits stale bits
  always_comb begin
    q_d = q_q;
    if (clr_i) begin
      q_d = '0;
    end else if (en_i) begin
      q_d = {bit_i, q_q[W-1:1]};
    end else begin
      q_d = q_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/spm_op_sequencer.sv
// Operand/result front-end for the serial-parallel multiplier. Define SPM_SIGNED_EN to
// sign-extend the serialised multiplier (two's complement operands); default is unsigned.
module spm_op_sequencer
  import spm_pkg::*;
#(
  parameter int N     = SPM_N,
  parameter int CNT_W = spm_cnt_w(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   in_mc,
  input  logic [N-1:0]   in_mp,
  output logic           start,
  output logic           proddone,
  input  logic           ld,
  input  logic           shift,
  input  logic           done,
  output logic [N-1:0]   mc,
  output logic           mp_bit,
  input  logic           p_bit,
  output logic           res_valid,
  input  logic           res_ready,
  output logic [2*N-1:0] res
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2 * N);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  seq_state_e       state_q;
  logic             start_q;
  logic             res_valid_q;
  logic [N-1:0]     mc_q;
  logic [N-1:0]     mp_sr_q;
  logic [CNT_W-1:0] cnt_q;

  logic accept_s;
  logic shift_en_s;
  logic fill_s;

  assign in_ready   = ld && (state_q == S_IDLE);
  assign accept_s   = in_valid && in_ready;
  // Shifts beyond 2N (the FSM's trailing shift cycle) must not disturb the result
  assign shift_en_s = (state_q == S_RUN) && shift && (cnt_q != CNT_MAX);

`ifdef SPM_SIGNED_EN
  assign fill_s = mp_sr_q[N-1];
`else
  assign fill_s = 1'b0;
`endif

  // Sequencer FSM with its registered handshake outputs, serialiser and shift counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      start_q     <= 1'b0;
      res_valid_q <= 1'b0;
      mc_q        <= '0;
      mp_sr_q     <= '0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (accept_s) begin
            state_q <= S_RUN;
            start_q <= 1'b1;
            mc_q    <= in_mc;
            mp_sr_q <= in_mp;
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          if (shift_en_s) begin
            mp_sr_q <= {fill_s, mp_sr_q[N-1:1]};
            cnt_q   <= cnt_q + CNT_ONE;
          end
          if (done) begin
            state_q     <= S_RES;
            res_valid_q <= 1'b1;
          end
        end
        S_RES: begin
          // start stays high here to park the control FSM in its done state
          if (res_ready) begin
            state_q     <= S_IDLE;
            start_q     <= 1'b0;
            res_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          start_q     <= 1'b0;
          res_valid_q <= 1'b0;
        end
      endcase
    end
  end

  spm_res_sipo #(
    .W (2 * N)
  ) u_res (
    .clk   (clk),
    .rst   (rst),
    .clr_i (accept_s),
    .en_i  (shift_en_s),
    .bit_i (p_bit),
    .q_o   (res)
  );

  assign start     = start_q;
  assign res_valid = res_valid_q;
  assign mc        = mc_q;
  assign mp_bit    = mp_sr_q[0];
  assign proddone  = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_spm_op_sequencer.sv
// Directed bench for spm_op_sequencer with a behavioural control FSM and serial multiplier.
module tb_spm_op_sequencer;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   in_mc = '0;
  logic [N-1:0]   in_mp = '0;
  logic           start, proddone, ld, shift, done;
  logic [N-1:0]   mc;
  logic           mp_bit, p_bit;
  logic           res_valid;
  logic           res_ready = 1'b0;
  logic [2*N-1:0] res;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  spm_op_sequencer #(.N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_mc(in_mc), .in_mp(in_mp), .start(start), .proddone(proddone),
    .ld(ld), .shift(shift), .done(done), .mc(mc), .mp_bit(mp_bit),
    .p_bit(p_bit), .res_valid(res_valid), .res_ready(res_ready), .res(res)
  );

  // Control FSM model: IDLE -> SHIFT on start, SHIFT -> DONE on proddone, DONE -> IDLE when start drops
  typedef enum logic [1:0] {F_IDLE = 2'd0, F_SHIFT = 2'd1, F_DONE = 2'd2} fsm_e;
  fsm_e fst;
  always @(posedge clk or posedge rst) begin
    if (rst) fst <= F_IDLE;
    else begin
      case (fst)
        F_IDLE:  if (start) fst <= F_SHIFT;
        F_SHIFT: if (proddone) fst <= F_DONE;
        F_DONE:  if (!start) fst <= F_IDLE;
        default: fst <= F_IDLE;
      endcase
    end
  end
  assign ld    = (fst == F_IDLE);
  assign shift = (fst == F_SHIFT);
  assign done  = (fst == F_DONE);

  // Serial multiplier model: accumulate partial products, emit bit k at shift k
  logic [2*N-1:0] mc_ext, acc, sum;
  int k;
`ifdef SPM_SIGNED_EN
  assign mc_ext = {{N{mc[N-1]}}, mc};
`else
  assign mc_ext = {{N{1'b0}}, mc};
`endif
  assign sum   = acc + (mp_bit ? (mc_ext << k) : '0);
  assign p_bit = (k < 2 * N) ? sum[k] : 1'b0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0; k <= 0;
    end else if (ld) begin
      acc <= '0; k <= 0;
    end else if (shift && k < 2 * N) begin
      acc <= sum; k <= k + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("issue_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1; in_mc = a; in_mp = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic collect(output int lat, output int nsh);
    lat = 0; nsh = 0;
    while (!res_valid && lat < 60) begin
      if (shift && !proddone) nsh++;
      @(posedge clk); #1; lat++;
    end
    chk("res_valid_timeout", {31'd0, res_valid}, 32'd1);
  endtask

  task automatic accept_res();
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nsh, gap, n_acc, n_res;
    logic a_f, r_f;
    logic [2*N-1:0] r_val, r0, r1, hold_res;

    // Reset state
    #3;
    chk("rst_start", {31'd0, start}, 32'd0);
    chk("rst_proddone", {31'd0, proddone}, 32'd0);
    chk("rst_res_valid", {31'd0, res_valid}, 32'd0);
    chk("rst_mc", {24'd0, mc}, 32'd0);
    chk("rst_mp_bit", {31'd0, mp_bit}, 32'd0);
    chk("rst_res", {16'd0, res}, 32'd0);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // 1. Unsigned 13*11, latency and shift count
    issue(8'd13, 8'd11);
    chk("t1_start_e0", {31'd0, start}, 32'd1);
    chk("t1_mc", {24'd0, mc}, 32'd13);
    chk("t1_mp_bit0", {31'd0, mp_bit}, 32'd1);
    collect(lat, nsh);
    chk("t1_latency", lat, 32'd19);
    chk("t1_shifts", nsh, 32'd16);
    chk("t1_res", {16'd0, res}, 32'h008F);
    accept_res();

    // 2. 0xFD * 0x05
    issue(8'hFD, 8'h05);
    collect(lat, nsh);
`ifdef SPM_SIGNED_EN
    chk("t2_res", {16'd0, res}, 32'hFFF1);
`else
    chk("t2_res", {16'd0, res}, 32'h04F1);
`endif

    // 3. Backpressure on the result
    hold_res = res;
    for (int i = 0; i < 10; i++) begin
      chk("t3_res_hold", {16'd0, res}, {16'd0, hold_res});
      chk("t3_valid_hold", {31'd0, res_valid}, 32'd1);
      chk("t3_start_hold", {31'd0, start}, 32'd1);
      chk("t3_in_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    accept_res();
    chk("t3_in_ready_after_acc", {31'd0, in_ready}, 32'd0);
    chk("t3_valid_drop", {31'd0, res_valid}, 32'd0);
    @(posedge clk); #1;
    chk("t3_ld", {31'd0, ld}, 32'd1);
    chk("t3_in_ready_back", {31'd0, in_ready}, 32'd1);

    // 4. Operand offered while busy is ignored
    issue(8'd7, 8'd9);
    repeat (4) begin @(posedge clk); #1; end
    in_valid = 1'b1; in_mc = 8'hFF; in_mp = 8'hFF;
    chk("t4_in_ready_busy", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("t4_mc_kept", {24'd0, mc}, 32'd7);
    collect(lat, nsh);
    chk("t4_res", {16'd0, res}, 32'h003F);
    accept_res();

    // 5. Reset mid-run at cnt=7, then 255*255
    issue(8'h21, 8'h33);
    repeat (8) begin @(posedge clk); #1; end
    chk("t5_running", {31'd0, shift}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_start", {31'd0, start}, 32'd0);
    chk("t5_rst_proddone", {31'd0, proddone}, 32'd0);
    chk("t5_rst_valid", {31'd0, res_valid}, 32'd0);
    chk("t5_rst_mc", {24'd0, mc}, 32'd0);
    chk("t5_rst_mp_bit", {31'd0, mp_bit}, 32'd0);
    chk("t5_rst_res", {16'd0, res}, 32'd0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    issue(8'hFF, 8'hFF);
    collect(lat, nsh);
`ifdef SPM_SIGNED_EN
    chk("t5_res", {16'd0, res}, 32'h0001);
`else
    chk("t5_res", {16'd0, res}, 32'hFE01);
`endif
    accept_res();

    // 6. Back-to-back with in_valid and res_ready held high
    in_valid = 1'b1; in_mc = 8'd2; in_mp = 8'd3; res_ready = 1'b1;
    n_acc = 0; n_res = 0; gap = 0; r0 = '0; r1 = '0;
    for (int c = 0; c < 150 && n_res < 2; c++) begin
      a_f = in_valid && in_ready;
      r_f = res_valid && res_ready;
      r_val = res;
      if (a_f && n_acc > 0) chk("t6_gap", {31'd0, (gap >= 1)}, 32'd1);
      if (!in_ready) gap++;
      @(posedge clk); #1;
      if (a_f) begin
        n_acc++;
        if (n_acc == 1) begin in_mc = 8'd4; in_mp = 8'd5; end
        else in_valid = 1'b0;
      end
      if (r_f) begin
        if (n_res == 0) r0 = r_val; else r1 = r_val;
        n_res++;
        gap = 0;
      end
    end
    res_ready = 1'b0; in_valid = 1'b0;
    chk("t6_n_accepts", n_acc, 32'd2);
    chk("t6_n_results", n_res, 32'd2);
    chk("t6_res0", {16'd0, r0}, 32'd6);
    chk("t6_res1", {16'd0, r1}, 32'd20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
